// File: rtl/n_io_bias_mac.sv
// n_io_bias_mac: sequential N-input multiply-accumulate with shift, bias and saturation.
// Ports: clk, rst (sync, active-high); in/weight_val/biased_val operands;
//   enable/ready start handshake; out_valid/out_ack result handshake;
//   biased_out saturated result, overflow set when biased_out was clipped.
module n_io_bias_mac #(
   parameter int N_IN    = 4,
   parameter int DATA_W  = 8,
   parameter int FRAC_SH = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_IN*DATA_W-1:0]   in,
   input  logic [N_IN*DATA_W-1:0]   weight_val,
   input  logic [DATA_W-1:0]        biased_val,
   input  logic                     enable,
   output logic                     ready,
   input  logic                     out_ack,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        biased_out,
   output logic                     overflow
);

   localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1;
   localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [ACC_W-1:0] MAXV = ACC_W'({DATA_W{1'b1}});

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_next;

   logic [N_IN*DATA_W-1:0]   r_in;
   logic [N_IN*DATA_W-1:0]   r_wt;
   logic [DATA_W-1:0]        r_bias;
   logic [ACC_W-1:0]         r_acc;
   logic [IDX_W-1:0]         r_idx;
   logic [DATA_W-1:0]        r_out;
   logic                     r_ovf;

   logic [DATA_W-1:0]        w_a;
   logic [DATA_W-1:0]        w_b;
   logic [2*DATA_W-1:0]      w_prod;
   logic [ACC_W-1:0]         w_sum;
   logic [ACC_W-1:0]         w_shift;
   logic [ACC_W-1:0]         w_biased;
   logic                     w_sat;
   logic                     w_last;
   logic                     w_start;

   // Operand select for the current element
   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_a = r_in[i*DATA_W +: DATA_W];
            w_b = r_wt[i*DATA_W +: DATA_W];
         end
      end
   end

   // The accumulator is wide enough that neither the sum nor the
   // bias add can wrap, so saturation is a plain magnitude compare.
   assign w_prod   = w_a * w_b;
   assign w_sum    = r_acc + ACC_W'(w_prod);
   assign w_shift  = w_sum >> FRAC_SH;
   assign w_biased = w_shift + ACC_W'(r_bias);
   assign w_sat    = (w_biased > MAXV);
   assign w_last   = (r_idx == IDX_W'(N_IN-1));
   assign w_start  = (r_state == S_IDLE) && enable;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (enable) w_next = S_MAC;
         end
         S_MAC: begin
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            if (out_ack) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register only
   always_comb begin
      ready     = 1'b0;
      out_valid = 1'b0;
      unique case (r_state)
         S_IDLE:  ready     = 1'b1;
         S_DONE:  out_valid = 1'b1;
         default: begin
            ready     = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Operand capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_in   <= '0;
         r_wt   <= '0;
         r_bias <= '0;
      end else if (w_start) begin
         r_in   <= in;
         r_wt   <= weight_val;
         r_bias <= biased_val;
      end
   end

   // Accumulator and element index
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_idx <= '0;
      end else if (w_start) begin
         r_acc <= '0;
         r_idx <= '0;
      end else if (r_state == S_MAC) begin
         r_acc <= w_sum;
         r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
   end

   // Result register: only loaded on the final accumulate edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= '0;
         r_ovf <= 1'b0;
      end else if ((r_state == S_MAC) && w_last) begin
         r_out <= w_sat ? {DATA_W{1'b1}} : w_biased[DATA_W-1:0];
         r_ovf <= w_sat;
      end
   end

   assign biased_out = r_out;
   assign overflow   = r_ovf;

endmodule
